// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the R-type control sequencer: opcodes, ALU strobe
// bit positions, FSM state encoding and opcode classification helpers.
package cpu_ctrl_pkg;

  localparam int OPC_BITS = 5;

  localparam logic [OPC_BITS-1:0] OPC_ADD  = 5'd3;
  localparam logic [OPC_BITS-1:0] OPC_SUB  = 5'd4;
  localparam logic [OPC_BITS-1:0] OPC_AND  = 5'd5;
  localparam logic [OPC_BITS-1:0] OPC_OR   = 5'd6;
  localparam logic [OPC_BITS-1:0] OPC_SHR  = 5'd7;
  localparam logic [OPC_BITS-1:0] OPC_SHRA = 5'd8;
  localparam logic [OPC_BITS-1:0] OPC_SHL  = 5'd9;
  localparam logic [OPC_BITS-1:0] OPC_ROR  = 5'd10;
  localparam logic [OPC_BITS-1:0] OPC_ROL  = 5'd11;
  localparam logic [OPC_BITS-1:0] OPC_MUL  = 5'd15;
  localparam logic [OPC_BITS-1:0] OPC_DIV  = 5'd16;
  localparam logic [OPC_BITS-1:0] OPC_NEG  = 5'd17;
  localparam logic [OPC_BITS-1:0] OPC_NOT  = 5'd18;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_MUL  = 4'd4;
  localparam logic [3:0] ALU_DIV  = 4'd5;
  localparam logic [3:0] ALU_SHR  = 4'd6;
  localparam logic [3:0] ALU_SHRA = 4'd7;
  localparam logic [3:0] ALU_SHL  = 4'd8;
  localparam logic [3:0] ALU_ROR  = 4'd9;
  localparam logic [3:0] ALU_ROL  = 4'd10;
  localparam logic [3:0] ALU_NEG  = 4'd11;
  localparam logic [3:0] ALU_NOT  = 4'd12;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH0 = 4'd1,
    ST_FETCH1 = 4'd2,
    ST_FETCH2 = 4'd3,
    ST_DECODE = 4'd4,
    ST_OPA    = 4'd5,
    ST_OPB    = 4'd6,
    ST_WRLO   = 4'd7,
    ST_WRHI   = 4'd8
  } state_t;

  function automatic logic is_unary(input logic [OPC_BITS-1:0] opc);
    return (opc == OPC_NEG) || (opc == OPC_NOT);
  endfunction

  function automatic logic is_muldiv(input logic [OPC_BITS-1:0] opc);
    return (opc == OPC_MUL) || (opc == OPC_DIV);
  endfunction

  function automatic logic is_legal(input logic [OPC_BITS-1:0] opc);
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR, OPC_SHRA, OPC_SHL,
      OPC_ROR, OPC_ROL, OPC_MUL, OPC_DIV, OPC_NEG, OPC_NOT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Maps an opcode to its one-hot position on the ALU select bus.
  function automatic logic [3:0] alu_index(input logic [OPC_BITS-1:0] opc);
    case (opc)
      OPC_AND:  return ALU_AND;
      OPC_OR:   return ALU_OR;
      OPC_ADD:  return ALU_ADD;
      OPC_SUB:  return ALU_SUB;
      OPC_MUL:  return ALU_MUL;
      OPC_DIV:  return ALU_DIV;
      OPC_SHR:  return ALU_SHR;
      OPC_SHRA: return ALU_SHRA;
      OPC_SHL:  return ALU_SHL;
      OPC_ROR:  return ALU_ROR;
      OPC_ROL:  return ALU_ROL;
      OPC_NEG:  return ALU_NEG;
      OPC_NOT:  return ALU_NOT;
      default:  return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ir_field_decode.sv
// Splits the instruction register into opcode and register fields and
// classifies the opcode. Purely combinational.
module ir_field_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int IR_W      = 32,
  parameter int OPC_W     = 5,
  parameter int REG_IDX_W = 4
) (
  input  logic [IR_W-1:0]      ir,
  output logic [OPC_W-1:0]     opcode,
  output logic [REG_IDX_W-1:0] ra,
  output logic [REG_IDX_W-1:0] rb,
  output logic [REG_IDX_W-1:0] rc,
  output logic                 legal,
  output logic                 unary,
  output logic                 muldiv
);

  localparam int LOW_W = IR_W - OPC_W - 3 * REG_IDX_W;

  logic unused_low_bits;

  assign opcode = ir[IR_W-1 -: OPC_W];
  assign ra     = ir[IR_W-OPC_W-1 -: REG_IDX_W];
  assign rb     = ir[IR_W-OPC_W-REG_IDX_W-1 -: REG_IDX_W];
  assign rc     = ir[IR_W-OPC_W-2*REG_IDX_W-1 -: REG_IDX_W];

  assign legal  = is_legal(opcode);
  assign unary  = is_unary(opcode);
  assign muldiv = is_muldiv(opcode);

  assign unused_low_bits = ^ir[LOW_W-1:0];

endmodule

// File: rtl/rtype_ctrl_seq.sv
// Hardwired control sequencer for register-register ALU instructions:
// fetch, decode, operand reads, ALU strobe and LO/HI or register writeback.
module rtype_ctrl_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = 4,
  parameter int OPC_W     = 5,
  parameter int IR_W      = 32,
  parameter int NUM_OPS   = 13
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [IR_W-1:0]     ir,
  output logic                pc_out,
  output logic                mar_in,
  output logic                inc_pc,
  output logic                pc_in,
  output logic                md_read,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                ir_in,
  output logic                y_in,
  output logic                z_in,
  output logic                zlow_out,
  output logic                zhigh_out,
  output logic                hi_in,
  output logic                lo_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_OPS-1:0]  alu_op,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  localparam logic [NUM_REGS-1:0] REG_ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};
  localparam logic [NUM_OPS-1:0]  OP_ONE  = {{(NUM_OPS-1){1'b0}}, 1'b1};

  state_t state, next_state;

  logic [OPC_W-1:0]     dec_opcode, opcode_q;
  logic [REG_IDX_W-1:0] dec_ra, dec_rb, dec_rc;
  logic [REG_IDX_W-1:0] ra_q, rb_q, rc_q;
  logic                 dec_legal, dec_unary, unused_dec_muldiv;
  logic                 op_unary, op_muldiv;

  ir_field_decode #(
    .IR_W      (IR_W),
    .OPC_W     (OPC_W),
    .REG_IDX_W (REG_IDX_W)
  ) u_ir_field_decode (
    .ir     (ir),
    .opcode (dec_opcode),
    .ra     (dec_ra),
    .rb     (dec_rb),
    .rc     (dec_rc),
    .legal  (dec_legal),
    .unary  (dec_unary),
    .muldiv (unused_dec_muldiv)
  );

  assign op_unary  = is_unary(opcode_q);
  assign op_muldiv = is_muldiv(opcode_q);

  // State register; reset drops straight back to IDLE from anywhere.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Capture the instruction fields once in DECODE so later states do not
  // depend on the IR staying stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opcode_q <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
    end else if (state == ST_DECODE) begin
      opcode_q <= dec_opcode;
      ra_q     <= dec_ra;
      rb_q     <= dec_rb;
      rc_q     <= dec_rc;
    end
  end

  // Next-state sequencing, including the memory wait and the unary/muldiv
  // branches.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start) next_state = ST_FETCH0;
      ST_FETCH0: next_state = ST_FETCH1;
      ST_FETCH1: if (mem_ready) next_state = ST_FETCH2;
      ST_FETCH2: next_state = ST_DECODE;
      ST_DECODE: begin
        if (!dec_legal)     next_state = ST_IDLE;
        else if (dec_unary) next_state = ST_OPB;
        else                next_state = ST_OPA;
      end
      ST_OPA:    next_state = ST_OPB;
      ST_OPB:    next_state = ST_WRLO;
      ST_WRLO:   next_state = op_muldiv ? ST_WRHI : ST_IDLE;
      ST_WRHI:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Moore strobe decode from the current state and latched fields.
  always_comb begin
    pc_out    = 1'b0;
    mar_in    = 1'b0;
    inc_pc    = 1'b0;
    pc_in     = 1'b0;
    md_read   = 1'b0;
    mdr_in    = 1'b0;
    mdr_out   = 1'b0;
    ir_in     = 1'b0;
    y_in      = 1'b0;
    z_in      = 1'b0;
    zlow_out  = 1'b0;
    zhigh_out = 1'b0;
    hi_in     = 1'b0;
    lo_in     = 1'b0;
    reg_out   = '0;
    reg_in    = '0;
    alu_op    = '0;
    busy      = (state != ST_IDLE);
    done      = 1'b0;
    illegal   = 1'b0;
    case (state)
      ST_FETCH0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
      end
      ST_FETCH1: begin
        md_read = 1'b1;
        mdr_in  = 1'b1;
      end
      ST_FETCH2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      ST_DECODE: illegal = !dec_legal;
      ST_OPA: begin
        reg_out = REG_ONE << rb_q;
        y_in    = 1'b1;
      end
      ST_OPB: begin
        alu_op  = OP_ONE << alu_index(opcode_q);
        z_in    = 1'b1;
        reg_out = REG_ONE << (op_unary ? rb_q : rc_q);
      end
      ST_WRLO: begin
        zlow_out = 1'b1;
        if (op_muldiv) lo_in = 1'b1;
        else           reg_in = REG_ONE << ra_q;
        done = !op_muldiv;
      end
      ST_WRHI: begin
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/rtype_ctrl_seq.md
Name: rtype_ctrl_seq

Overview:
Hardwired control sequencer for register-register ALU instructions on the single-bus datapath. It fetches an instruction, decodes the IR fields, and drives the one-hot bus-source, register-enable and ALU-select strobes for one instruction per start request. This replaces hand-stepped T0..Tn stimulus with a real control block. It adds a memory-ready handshake, unary ops, a HI/LO writeback for MUL/DIV, and illegal-opcode detection.

Parameters:
NUM_REGS, 16, general registers R0..R(NUM_REGS-1); must be a power of 2.
REG_IDX_W, 4, IR register-field width, log2(NUM_REGS).
OPC_W, 5, IR opcode width.
IR_W, 32, instruction width.
NUM_OPS, 13, ALU select width.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low; 0 forces IDLE.
start  in  1  begin one instruction; sampled in IDLE only.
mem_ready  in  1  memory read data valid.
ir  in  IR_W  current IR register contents.
pc_out, mar_in, inc_pc, pc_in  out  1  PC/MAR strobes.
md_read, mdr_in, mdr_out, ir_in  out  1  memory/IR strobes.
y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in  out  1  ALU path strobes.
reg_out  out  NUM_REGS  one-hot register bus drive.
reg_in  out  NUM_REGS  one-hot register write enable.
alu_op  out  NUM_OPS  one-hot, bit order AND,OR,ADD,SUB,MUL,DIV,SHR,SHRA,SHL,ROR,ROL,NEG,NOT (bit0=AND).
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse in the final writeback state.
illegal  out  1  one-cycle pulse in DECODE when the opcode is unsupported.

Behaviour:
- IR fields: opcode=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15] (IR_W=32 layout).
- Opcodes: ADD=3, SUB=4, AND=5, OR=6, SHR=7, SHRA=8, SHL=9, ROR=10, ROL=11, MUL=15, DIV=16, NEG=17, NOT=18. All others are illegal.
- Outputs are Moore: decoded combinationally from the state register and the latched fields. Every output is 0 in IDLE and under reset.
- At most one reg_out bit and at most one bus source are active per cycle.
- States and the strobes asserted in each:
  - IDLE: no strobes. start=1 -> FETCH0; otherwise stay.
  - FETCH0: pc_out, mar_in, inc_pc -> FETCH1.
  - FETCH1: md_read, mdr_in. Stay while mem_ready=0; mem_ready=1 -> FETCH2.
  - FETCH2: mdr_out, ir_in -> DECODE.
  - DECODE: no strobes. Latch opcode/ra/rb/rc from ir.
    - Illegal opcode: illegal=1, -> IDLE.
    - NEG/NOT: -> OPB.
    - Otherwise: -> OPA.
  - OPA: reg_out[rb], y_in -> OPB.
  - OPB: alu_op[op], z_in. reg_out[rc] for binary ops; reg_out[rb] for NEG/NOT. -> WRLO.
  - WRLO: zlow_out. reg_in[ra], or lo_in for MUL/DIV.
    - MUL/DIV: -> WRHI.
    - Otherwise: done=1, -> IDLE.
  - WRHI: zhigh_out, hi_in, done=1 -> IDLE.
- Latency from the start edge to done, with mem_ready high in FETCH1: binary 7 cycles, unary 6, MUL/DIV 8. Add one cycle per FETCH1 wait cycle.
- start while busy is ignored. start held high in the cycle done is asserted starts the next instruction immediately after IDLE (one IDLE cycle between instructions).
- Reset asserted mid-operation: state -> IDLE and latched fields -> 0 asynchronously. All strobes drop in the same cycle; no partial writeback completes.
- ra=rb=rc is legal: OPA/OPB read before WRLO writes.
- ra may be R0; R0 is written like any other register.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams;
  - ALU one-hot bit indices;
  - state encoding (4-bit, IDLE=0);
  - helper functions is_unary(opc), is_muldiv(opc), is_legal(opc).
- One sub-module, ir_field_decode (combinational): takes ir and produces opcode, ra, rb, rc, legal, unary, muldiv.
- The FSM and strobe decode live in rtype_ctrl_seq.

Test Plan:
- SUB, ir=0x221B8000, mem_ready=1 -> OPA reg_out=0x0008 with y_in; OPB reg_out=0x0080 with alu_op bit3; WRLO reg_in=0x0010 with zlow_out; done on cycle 7; busy low on cycle 8.
- MUL, ir=0x781B8000 -> OPB alu_op bit4; WRLO lo_in=1 with reg_in=0; WRHI hi_in=1 with zhigh_out; done on cycle 8.
- NEG, ir=0x88980000 -> OPA skipped; OPB reg_out=0x0008 with alu_op bit11; WRLO reg_in=0x0002; done on cycle 6.
- SUB with mem_ready held low 3 cycles in FETCH1 -> md_read/mdr_in held 4 cycles; done on cycle 10.
- Illegal, ir=0xF8000000 -> illegal pulses in DECODE; no reg_in, z_in or done ever; IDLE next cycle.
- Reset driven low in OPB of SUB -> all outputs 0 in that cycle; after release, IDLE; reg_in never asserted.
